div_req_sequencer: RTL and testbench

DIV_REQ_SEQUENCER -- requirements
Module: div_req_sequencer

---
 rtl/div_req_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_div_req_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sequencer.sv
// Queues divide requests and feeds them one at a time to an external divider; a result is held until it is accepted.
// Latency: push, pop, issue, divider latency, capture. in_ready drops when the queue is full; pops stall while a result is held.
module div_req_sequencer #(
    parameter int DEPTH = 4,
    parameter int WDOG  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_X,
    input  logic [3:0] in_Y,
    output logic       div_start,
    output logic [3:0] div_X,
    output logic [3:0] div_Y,
    input  logic       div_valid,
    input  logic [3:0] div_quot,
    input  logic [3:0] div_rem,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_quot,
    output logic [3:0] out_rem,
    output logic       out_dz,
    output logic       out_err
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WDW = $clog2(WDOG + 1);

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    req_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [WDW-1:0]  r_wdog;
    logic [3:0]      r_div_x;
    logic [3:0]      r_div_y;
    logic            r_out_valid;
    logic [3:0]      r_out_quot;
    logic [3:0]      r_out_rem;
    logic            r_out_dz;
    logic            r_out_err;

    logic            w_push;
    logic            w_pop;
    logic            w_zero;
    logic            w_capture;
    logic            w_timeout;
    req_t            w_head;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_head    = r_mem[r_rptr];

    assign div_X     = r_div_x;
    assign div_Y     = r_div_y;
    assign out_valid = r_out_valid;
    assign out_quot  = r_out_quot;
    assign out_rem   = r_out_rem;
    assign out_dz    = r_out_dz;
    assign out_err   = r_out_err;

    // A pop is only allowed with the output slot empty, so it never shares a cycle with a handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_zero      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        div_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !r_out_valid) begin
                    w_pop = 1'b1;
                    if (w_head.y == 4'd0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                div_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == WDW'(WDOG - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{x: in_X, y: in_Y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_wdog      <= '0;
            r_div_x     <= '0;
            r_div_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_quot  <= '0;
            r_out_rem   <= '0;
            r_out_dz    <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_div_x <= w_head.x;
                r_div_y <= w_head.y;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if ((r_state == S_WAIT) && !div_valid) begin
                r_wdog <= r_wdog + WDW'(1);
            end

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Set sources below are only reachable while the slot is empty.
            if (w_zero) begin
                r_out_valid <= 1'b1;
                r_out_quot  <= 4'hF;
                r_out_rem   <= w_head.x;
                r_out_dz    <= 1'b1;
                r_out_err   <= 1'b0;
            end else if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_quot  <= div_quot;
                r_out_rem   <= div_rem;
                r_out_dz    <= 1'b0;
                r_out_err   <= 1'b0;
            end else if (w_timeout) begin
                r_out_valid <= 1'b1;
                r_out_quot  <= 4'd0;
                r_out_rem   <= 4'd0;
                r_out_dz    <= 1'b0;
                r_out_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a fixed-latency divider model driven on the falling edge.
module tb_div_req_sequencer;

    localparam int DIV_LAT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_X = 4'd0;
    logic [3:0] in_Y = 4'd0;
    logic       div_start;
    logic [3:0] div_X;
    logic [3:0] div_Y;
    logic       div_valid = 1'b0;
    logic [3:0] div_quot = 4'd0;
    logic [3:0] div_rem = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_quot;
    logic [3:0] out_rem;
    logic       out_dz;
    logic       out_err;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int push_to = 0;
    int dcnt = 0;
    bit div_auto = 1'b1;
    bit force_req = 1'b0;
    logic [9:0] exp_r [0:5];

    div_req_sequencer #(.DEPTH(4), .WDOG(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_X(in_X), .in_Y(in_Y),
        .div_start(div_start), .div_X(div_X), .div_Y(div_Y),
        .div_valid(div_valid), .div_quot(div_quot), .div_rem(div_rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_dz(out_dz), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_start) start_cnt = start_cnt + 1;
    end

    // Divider model: result valid DIV_LAT cycles after the start cycle.
    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) hit = 1'b1;
        end
        if (div_start && div_auto) dcnt = DIV_LAT;
        div_valid = (hit && div_auto) || force_req;
        force_req = 1'b0;
        div_quot  = (div_Y != 4'd0) ? div_X / div_Y : 4'd0;
        div_rem   = (div_Y != 4'd0) ? div_X % div_Y : 4'd0;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        in_valid = 1'b1;
        in_X = x;
        in_Y = y;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) push_to++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int n, output bit to);
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL rst_div_start got=%b exp=0", div_start); end
        checks++; if ({div_X, div_Y} !== 8'h00) begin failures++; $display("FAIL rst_div_xy got=%h exp=00", {div_X, div_Y}); end
        checks++; if ({out_quot, out_rem} !== 8'h00) begin failures++; $display("FAIL rst_out_qr got=%h exp=00", {out_quot, out_rem}); end
        checks++; if ({out_dz, out_err} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {out_dz, out_err}); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_div();
        int n; bit to; int base;
        base = start_cnt;
        push(4'd13, 4'd4);
        wait_out(60, n, to);
        checks++; if (to || n != 7) begin failures++; $display("FAIL basic_latency got=%0d exp=7", n); end
        checks++; if ({out_quot, out_rem} !== 8'h31) begin failures++; $display("FAIL basic_qr got=%h exp=31", {out_quot, out_rem}); end
        checks++; if ({out_dz, out_err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {out_dz, out_err}); end
        checks++; if (start_cnt - base != 1) begin failures++; $display("FAIL basic_start_pulses got=%0d exp=1", start_cnt - base); end
        repeat (3) @(negedge clk);
        checks++; if ({out_valid, out_quot, out_rem} !== 9'h131) begin failures++; $display("FAIL basic_hold got=%h exp=131", {out_valid, out_quot, out_rem}); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_clear got=%b exp=0", out_valid); end
    endtask

    task automatic test_div_zero();
        int n; bit to; int base;
        base = start_cnt;
        push(4'd7, 4'd0);
        wait_out(60, n, to);
        checks++; if (to || n != 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", n); end
        checks++; if ({out_dz, out_err, out_quot, out_rem} !== 10'h2F7) begin failures++; $display("FAIL dz_result got=%h exp=2f7", {out_dz, out_err, out_quot, out_rem}); end
        repeat (10) @(negedge clk);
        checks++; if (start_cnt - base != 0) begin failures++; $display("FAIL dz_no_start got=%0d exp=0", start_cnt - base); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base; int pn;
        do_reset();
        exp_r[0] = 10'h031; exp_r[1] = 10'h041; exp_r[2] = 10'h050;
        exp_r[3] = 10'h013; exp_r[4] = 10'h2F8; exp_r[5] = 10'h024;
        base = start_cnt;
        push(4'd13, 4'd4);
        push(4'd9, 4'd2);
        push(4'd15, 4'd3);
        push(4'd10, 4'd7);
        push(4'd8, 4'd0);
        in_valid = 1'b1; in_X = 4'd14; in_Y = 4'd5;
        repeat (10) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_in_ready got=%b exp=0", in_ready); end
        checks++; if ({out_valid, out_quot, out_rem} !== 9'h131) begin failures++; $display("FAIL b2b_held_first got=%h exp=131", {out_valid, out_quot, out_rem}); end
        checks++; if (start_cnt - base != 1) begin failures++; $display("FAIL b2b_stall_starts got=%0d exp=1", start_cnt - base); end
        fork
            begin
                pn = 0;
                while (!in_ready && pn < 200) begin
                    @(negedge clk);
                    pn++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    int n; bit to;
                    wait_out(60, n, to);
                    checks++;
                    if (to || {out_dz, out_err, out_quot, out_rem} !== exp_r[i]) begin
                        failures++;
                        $display("FAIL b2b_result%0d got=%h exp=%h timeout=%0d", i, {out_dz, out_err, out_quot, out_rem}, exp_r[i], to);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b0;
            end
        join
        checks++; if (pn >= 200) begin failures++; $display("FAIL b2b_last_push got=timeout exp=accepted"); end
    endtask

    task automatic test_watchdog();
        int n; bit to;
        div_auto = 1'b0;
        push(4'd9, 4'd2);
        wait_out(60, n, to);
        checks++; if (to || n != 17) begin failures++; $display("FAIL wdog_latency got=%0d exp=17", n); end
        checks++; if ({out_dz, out_err, out_quot, out_rem} !== 10'h100) begin failures++; $display("FAIL wdog_result got=%h exp=100", {out_dz, out_err, out_quot, out_rem}); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        div_auto = 1'b1;
        push(4'd9, 4'd2);
        wait_out(60, n, to);
        checks++; if (to || {out_dz, out_err, out_quot, out_rem} !== 10'h041) begin failures++; $display("FAIL wdog_next_req got=%h exp=041", {out_dz, out_err, out_quot, out_rem}); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int base;
        div_auto = 1'b0;
        push(4'd12, 4'd5);
        push(4'd11, 4'd3);
        push(4'd5, 4'd1);
        repeat (3) @(negedge clk);
        base = start_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_req = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmw_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmw_in_ready got=%b exp=1", in_ready); end
        checks++; if (start_cnt - base != 0) begin failures++; $display("FAIL rmw_starts got=%0d exp=0", start_cnt - base); end
        div_auto = 1'b1;
    endtask

    task automatic test_push_pop_same();
        int n; bit to;
        do_reset();
        exp_r[0] = 10'h041; exp_r[1] = 10'h050; exp_r[2] = 10'h013;
        exp_r[3] = 10'h020; exp_r[4] = 10'h051;
        push(4'd13, 4'd4);
        push(4'd9, 4'd2);
        push(4'd15, 4'd3);
        push(4'd10, 4'd7);
        wait_out(60, n, to);
        checks++; if (to || {out_quot, out_rem} !== 8'h31) begin failures++; $display("FAIL pps_first got=%h exp=31", {out_quot, out_rem}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pps_three_queued got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_X = 4'd6; in_Y = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pps_count_kept got=%b exp=1", in_ready); end
        push(4'd11, 4'd2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pps_full_after got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_out(60, n, to);
            checks++;
            if (to || {out_dz, out_err, out_quot, out_rem} !== exp_r[i]) begin
                failures++;
                $display("FAIL pps_result%0d got=%h exp=%h timeout=%0d", i, {out_dz, out_err, out_quot, out_rem}, exp_r[i], to);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pps_no_extra got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_div();
        test_div_zero();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_wait();
        test_push_pop_same();
        checks++; if (push_to !== 0) begin failures++; $display("FAIL push_timeouts got=%0d exp=0", push_to); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
